// File: rtl/divisor.sv
// ---------------------------------------------------------------------------
// divisor -- sequential unsigned restoring divider, 2N-bit / N-bit.
//
// A start request in IDLE or DONE captures the operands and enters CHECK.
// CHECK detects a quotient that will not fit in N bits (this includes a zero
// divisor) and finishes at once with Overflow=1. Otherwise DIV runs exactly
// N restoring steps, one per clock, and then the result is held in DONE.
//
// Handshake: St is a request level sampled only in IDLE and DONE. It is
// ignored in CHECK and DIV. Done is a level that stays high until the next
// start edge or reset. While Done=1 the Quociente, Resto and Overflow
// outputs are valid and stable. Busy is high exactly in CHECK and DIV.
//
// Ports
//   Clk          in   clock, rising edge
//   Reset        in   synchronous, active-low reset
//   St           in   start request
//   Dividendo    in   2N-bit unsigned dividend (captured at the start edge)
//   Divisor      in   N-bit unsigned divisor (captured at the start edge)
//   Quociente    out  N-bit quotient
//   Resto        out  N-bit remainder
//   Done         out  result valid
//   Busy         out  operation in progress
//   Overflow     out  divide by zero or quotient wider than N bits
//   dbg_state_o  out  current FSM state (0 IDLE, 1 CHECK, 2 DIV, 3 DONE)
// ---------------------------------------------------------------------------
module divisor #(
    parameter int N = 16
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           St,
    input  logic [2*N-1:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quociente,
    output logic [N-1:0]   Resto,
    output logic           Done,
    output logic           Busy,
    output logic           Overflow,
    output logic [1:0]     dbg_state_o
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [2*N:0]    rq_q;     // [2N:N] partial remainder, [N-1:0] quotient bits
    logic [N-1:0]    dvs_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    quo_q;
    logic [N-1:0]    rem_q;
    logic            done_q;
    logic            busy_q;
    logic            ovf_q;

    // One restoring step. The compare and subtract use the full N+1 upper
    // bits: after the shift the partial remainder can exceed 2^N - 1.
    logic [2*N:0]    shifted;
    logic [N:0]      upper;
    logic [N:0]      trial;
    logic            fits;
    logic [2*N:0]    step_d;

    always_comb begin
        shifted = {rq_q[2*N-1:0], 1'b0};
        upper   = shifted[2*N:N];
        trial   = upper - {1'b0, dvs_q};
        fits    = (upper >= {1'b0, dvs_q});
        step_d  = shifted;
        if (fits) begin
            step_d = {trial, shifted[N-1:1], 1'b1};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            rq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (St) begin
                        rq_q    <= {1'b0, Dividendo};
                        dvs_q   <= Divisor;
                        cnt_q   <= '0;
                        quo_q   <= '0;
                        rem_q   <= '0;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // Quotient fits in N bits only if the upper half of the
                    // dividend is strictly below the divisor.
                    if (rq_q[2*N-1:N] >= dvs_q) begin
                        quo_q   <= '0;
                        rem_q   <= '0;
                        ovf_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rq_q  <= step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        quo_q   <= step_d[N-1:0];
                        rem_q   <= step_d[2*N-1:N];
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Quociente   = quo_q;
    assign Resto       = rem_q;
    assign Done        = done_q;
    assign Busy        = busy_q;
    assign Overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 Parameter: N, 16, divisor/quotient/remainder width; dividend is 2N bits.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-low.
REQ-004 St  input  1  start request, sampled only in IDLE and DONE.
REQ-005 Dividendo  input  2N  unsigned dividend, captured at the start edge.
REQ-006 Divisor  input  N  unsigned divisor, captured at the start edge.
REQ-007 Quociente  output  N  unsigned quotient, valid while Done=1.
REQ-008 Resto  output  N  unsigned remainder, valid while Done=1.
REQ-009 Done  output  1  level; result valid.
REQ-010 Busy  output  1  level; operation in progress (CHECK or DIV).
REQ-011 Overflow  output  1  level, valid while Done=1; Divisor=0 or quotient does not fit in N bits.

Function
REQ-012 The block SHALL be an FSM with states IDLE, CHECK, DIV, DONE, plus a 2N+1-bit remainder/quotient register, a captured divisor register and an iteration counter, log2(N)+1 bits wide.
REQ-013 On a start edge (IDLE or DONE, St=1), the block SHALL load Dividendo into register bits [2N-1:0] with bit 2N cleared, load Divisor, clear Done/Overflow and enter CHECK.
REQ-014 In IDLE and DONE with St=0, the block SHALL hold state; outputs remain stable.
REQ-015 In CHECK, if register[2N-1:N] >= captured divisor (this covers Divisor=0), the block SHALL enter DONE with Overflow=1, Quociente=0 and Resto=0.
REQ-016 Otherwise CHECK SHALL enter DIV with counter=0.
REQ-017 Each DIV cycle SHALL perform one restoring step:
  - shift the register left by 1;
  - trial-subtract the divisor from the upper N+1 bits (N+1-bit compare, no truncation);
  - if the result is non-negative, replace the upper bits with the difference and set the LSB to 1; else set the LSB to 0.
REQ-018 After exactly N DIV cycles, the block SHALL enter DONE with Quociente = register[N-1:0], Resto = register[2N-1:N] and Overflow=0.
REQ-019 Latency: with the start at edge k, Done SHALL be 1 after edge k+N+1 in the normal case and after edge k+1 in the overflow case.
REQ-020 Busy SHALL be 1 exactly in CHECK and DIV.
REQ-021 St during CHECK/DIV SHALL be ignored; the operand inputs SHALL be ignored except at the start edge.
REQ-022 St=1 in DONE SHALL start a new operation on that edge (back-to-back), with Done falling after that edge.
REQ-023 The result SHALL satisfy Dividendo = Quociente*Divisor + Resto, with Resto < Divisor, whenever Overflow=0.
REQ-024 Consistency: a Dividendo equal to a product A*B of N-bit operands with A != 0 and Divisor=A SHALL yield Quociente=B and Resto=0.

Reset
REQ-025 Reset=0 at a clock edge SHALL force IDLE, all registers 0, Quociente=0, Resto=0, Done=0, Busy=0, Overflow=0.
REQ-026 Reset has priority over St and SHALL abort an operation in CHECK or DIV with no partial result exposed.
REQ-027 Reset=0 with no clock edge SHALL have no effect.

Verification
REQ-028 Dividendo=100, Divisor=7, St pulse at edge k -> Busy edges k..k+N; at edge k+17: Done=1, Quociente=14, Resto=2, Overflow=0.
REQ-029 Dividendo=0xFFFEFFFF, Divisor=0xFFFF -> Quociente=0xFFFF, Resto=0xFFFE, Overflow=0 (exercises the N+1-bit trial subtract).
REQ-030 Divisor=0 (any dividend), and separately Dividendo=0x00010000 with Divisor=0x0001 -> Done at edge k+1, Overflow=1, Quociente=0, Resto=0.
REQ-031 Reset=0 for one edge during DIV iteration 8 -> all outputs 0 after that edge, state IDLE; the next St yields a correct result.
REQ-032 St held high for 40 cycles with Dividendo=0x0000FFFF, Divisor=0x0100 -> back-to-back results, each Quociente=0x00FF and Resto=0x00FF; operand changes mid-operation have no effect.
REQ-033 Random check: 10k random A, B (A != 0), Dividendo=A*B+r with r<A -> Quociente=B, Resto=r, Overflow=0.
